disp_frame_sched: RTL and testbench
===================================

# disp_frame_sched

Frame scheduler between the acquisition engine and the LCD renderer. It re-arms capture and waits for a completed capture. It then grants the waveform renderer one frame (display_en/display_done), grants the status-text renderer a refresh when one is due, and enforces a minimum frame period. Stop, pause, configuration changes and a hung renderer are handled without dropping the LCD bus mid-transfer. Runs on clk_100 alongside the data handler and LCD modules.

## Interface
- FRAME_MIN_CYC, 1666666, minimum cycles between successive display_en rising edges (60 Hz at 100 MHz); must be ≥1 and <2^24
- TEXT_DIV, 8, text refresh every TEXT_DIV completed waveform frames; ≥1
- TIMEOUT_CYC, 10000000, maximum cycles a renderer grant may stay open; <2^24
- clk  in  1  system clock (clk_100)
- rst_n  in  1  asynchronous active-low reset
- acq_ready  in  1  level; capture buffer complete and readable
- stop  in  1  level; freeze acquisition, keep last capture
- pause  in  1  level; freeze acquisition and waveform redraw
- cfg_change  in  1  one-cycle pulse; any displayed parameter changed
- display_done  in  1  one-cycle pulse from waveform renderer
- text_done  in  1  one-cycle pulse from text renderer
- acq_rearm  out  1  one-cycle pulse; start a new capture
- display_en  out  1  waveform renderer grant (level)
- text_en  out  1  text renderer grant (level)
- busy  out  1  high in WAVE or TEXT
- frame_cnt  out  16  completed waveform frames, wraps 0xFFFF→0
- timeout_err  out  1  sticky; a grant timed out

## Operation
- States: ARM, WAIT_ACQ, WAVE, TEXT, HOLD. Reset state ARM.
- ARM: acq_rearm=1 for one cycle, then go to WAIT_ACQ.
- WAIT_ACQ:
  - acq_ready=1 and stop=0 and pause=0 → WAVE.
  - stop=1 or pause=1 → HOLD, with no rearm.
- WAVE:
  - display_en=1.
  - On display_done: frame_cnt+1 and text_div_cnt+1.
  - Then go to TEXT if text is due (text_div_cnt reached TEXT_DIV, or cfg_pend=1). Otherwise go to HOLD.
- TEXT:
  - text_en=1.
  - On entry, cfg_pend and text_div_cnt are cleared.
  - On text_done → HOLD.
- HOLD: wait until period_cnt ≥ FRAME_MIN_CYC, then:
  - stop=0 and pause=0 → ARM.
  - stop=1 and cfg_pend=1 → WAVE. This redraws the frozen capture; acq_ready is not required.
  - pause=1 and cfg_pend=1 → TEXT only.
  - Otherwise remain in HOLD.
- cfg_pend:
  - Set by a cfg_change pulse in any state.
  - If cfg_change coincides with TEXT entry, the set wins, so the change gets a later refresh.
- period_cnt: 24-bit. Cleared on every entry to WAVE, otherwise increments and saturates at FRAME_MIN_CYC.
- Timeout: a 24-bit grant_cnt is cleared on entry to WAVE or TEXT. If it reaches TIMEOUT_CYC:
  - the grant drops,
  - timeout_err is set,
  - the FSM goes to HOLD,
  - frame_cnt is not incremented.
- timeout_err is cleared only by reset.
- Ignored inputs: display_done outside WAVE and text_done outside TEXT. A done pulse on the same cycle as the timeout counts as done.
- Mutual exclusion: display_en and text_en are never high together, and neither is high during acq_rearm.

## Timing
- All outputs are registered.
- Reset values: acq_rearm=0, display_en=0, text_en=0, busy=0, frame_cnt=0, timeout_err=0. Internal registers: cfg_pend=0, counters=0.
- After rst_n deasserts, acq_rearm pulses on the 1st clk edge (ARM).
- acq_ready high in WAIT_ACQ → display_en high 1 cycle later.
- display_done at cycle t → display_en low at t+1. In the same cycle, text_en goes high if text is due.
- text_done at cycle t → text_en low at t+1.
- HOLD→ARM: acq_rearm pulses the cycle after period_cnt reaches FRAME_MIN_CYC. Minimum display_en rise-to-rise spacing is FRAME_MIN_CYC+3 cycles.
- stop/pause asserted during WAVE or TEXT: the open grant completes normally (no bus abort). They take effect at the next HOLD/WAIT_ACQ decision.
- Asynchronous reset mid-grant: display_en and text_en drop immediately, and the FSM restarts in ARM.

## Test plan
- Reset: hold rst_n=0 with acq_ready=1 → all outputs 0. Release → acq_rearm pulses once, display_en rises one cycle after WAIT_ACQ samples acq_ready.
- Normal run with FRAME_MIN_CYC=100, TEXT_DIV=2, renderer done after 20 cycles:
  - text_en follows every 2nd frame.
  - frame_cnt=4 after four frames.
  - display_en rises exactly 103 cycles apart.
- cfg_change during frame 1 with TEXT_DIV=8 → text_en asserts right after frame 1 completes. A cfg_change on the TEXT entry cycle causes one further text refresh later.
- stop=1 held, then cfg_change → one WAVE+TEXT pair with no acq_rearm. Without cfg_change, no grants.
- pause=1, then cfg_change → text_en only, display_en stays 0.
- TIMEOUT_CYC=50, display_done withheld → display_en drops after 50 cycles, timeout_err=1 and stays 1, frame_cnt unchanged, FSM resumes with acq_rearm. A late display_done is ignored.

Source files
------------

// File: rtl/disp_frame_sched.sv
// Frame scheduler: re-arms capture, then grants the waveform and text
// renderers in turn while holding a minimum frame period.
module disp_frame_sched #(
    parameter int unsigned FRAME_MIN_CYC = 1666666,
    parameter int unsigned TEXT_DIV      = 8,
    parameter int unsigned TIMEOUT_CYC   = 10000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        acq_ready,
    input  logic        stop,
    input  logic        pause,
    input  logic        cfg_change,
    input  logic        display_done,
    input  logic        text_done,
    output logic        acq_rearm,
    output logic        display_en,
    output logic        text_en,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        ARM, WAIT_ACQ, WAVE, TEXT, HOLD
    } state_t;

    localparam int unsigned TW = $clog2(TEXT_DIV + 1);
    localparam logic [23:0] FRAME_MIN = 24'(FRAME_MIN_CYC);
    localparam logic [23:0] GRANT_LIM =
        (TIMEOUT_CYC == 0) ? 24'd0 : 24'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TEXT_LIM = TW'(TEXT_DIV - 1);

    state_t        state;
    state_t        state_n;
    logic          cfg_pend;
    logic [TW-1:0] text_div_cnt;
    logic [23:0]   period_cnt;
    logic [23:0]   grant_cnt;

    logic wave_done;
    logic text_fin;
    logic grant_to;
    logic text_due;
    logic period_ok;

    logic rearm_d;
    logic de_d;
    logic te_d;
    logic busy_d;
    logic wave_entry;
    logic text_entry;
    logic to_set;

    assign wave_done = (state == WAVE) && display_done;
    assign text_fin  = (state == TEXT) && text_done;
    // Grant closes on the edge where grant_cnt would reach the limit
    assign grant_to  = grant_cnt >= GRANT_LIM;
    assign text_due  = (text_div_cnt >= TEXT_LIM) || cfg_pend;
    assign period_ok = period_cnt >= FRAME_MIN;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ARM;
            acq_rearm   <= 1'b0;
            display_en  <= 1'b0;
            text_en     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            acq_rearm   <= rearm_d;
            display_en  <= de_d;
            text_en     <= te_d;
            busy        <= busy_d;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ARM: state_n = WAIT_ACQ;
            WAIT_ACQ: begin
                if (stop || pause)
                    state_n = HOLD;
                else if (acq_ready)
                    state_n = WAVE;
            end
            WAVE: begin
                if (wave_done)
                    state_n = text_due ? TEXT : HOLD;
                else if (grant_to)
                    state_n = HOLD;
            end
            TEXT: begin
                if (text_fin || grant_to)
                    state_n = HOLD;
            end
            HOLD: begin
                if (period_ok) begin
                    unique case (1'b1)
                        (!stop && !pause):    state_n = ARM;
                        (stop && cfg_pend):   state_n = WAVE;
                        (pause && cfg_pend):  state_n = TEXT;
                        default:              state_n = HOLD;
                    endcase
                end
            end
            default: state_n = ARM;
        endcase
    end

    always_comb begin
        rearm_d    = (state == ARM);
        de_d       = (state_n == WAVE);
        te_d       = (state_n == TEXT);
        busy_d     = de_d || te_d;
        wave_entry = (state_n == WAVE) && (state != WAVE);
        text_entry = (state_n == TEXT) && (state != TEXT);
        to_set     = grant_to &&
                     (((state == WAVE) && !display_done) ||
                      ((state == TEXT) && !text_done));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt    <= 16'd0;
            timeout_err  <= 1'b0;
            cfg_pend     <= 1'b0;
            text_div_cnt <= '0;
            period_cnt   <= 24'd0;
            grant_cnt    <= 24'd0;
        end else begin
            if (wave_done)
                frame_cnt <= frame_cnt + 16'd1;
            if (to_set)
                timeout_err <= 1'b1;
            // A change landing on TEXT entry stays pending for a later refresh
            if (cfg_change)
                cfg_pend <= 1'b1;
            else if (text_entry)
                cfg_pend <= 1'b0;
            if (text_entry)
                text_div_cnt <= '0;
            else if (wave_done)
                text_div_cnt <= text_div_cnt + TW'(1);
            if (wave_entry)
                period_cnt <= 24'd0;
            else if (!period_ok)
                period_cnt <= period_cnt + 24'd1;
            if (wave_entry || text_entry)
                grant_cnt <= 24'd0;
            else if (((state == WAVE) || (state == TEXT)) && !grant_to)
                grant_cnt <= grant_cnt + 24'd1;
        end
    end

endmodule

// File: tb/tb_disp_frame_sched.sv
// Directed bench for disp_frame_sched with a short frame period,
// text every second frame and a 50-cycle grant timeout.
module tb_disp_frame_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        acq_ready;
    logic        stop;
    logic        pause;
    logic        cfg_change;
    logic        display_done;
    logic        text_done;
    logic        acq_rearm;
    logic        display_en;
    logic        text_en;
    logic        busy;
    logic [15:0] frame_cnt;
    logic        timeout_err;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_text = 0;
    int n_rearm = 0;
    int rise_t[$];
    logic de_q = 1'b0;
    logic te_q = 1'b0;

    disp_frame_sched #(
        .FRAME_MIN_CYC(100),
        .TEXT_DIV(2),
        .TIMEOUT_CYC(50)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .acq_ready(acq_ready),
        .stop(stop),
        .pause(pause),
        .cfg_change(cfg_change),
        .display_done(display_done),
        .text_done(text_done),
        .acq_rearm(acq_rearm),
        .display_en(display_en),
        .text_en(text_en),
        .busy(busy),
        .frame_cnt(frame_cnt),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (display_en && !de_q)
            rise_t.push_back(cyc);
        if (text_en && !te_q)
            n_text++;
        if (acq_rearm)
            n_rearm++;
        de_q = display_en;
        te_q = text_en;
        if (rst_n === 1'b1) begin
            n_chk++;
            assert (!(display_en && text_en) &&
                    !(acq_rearm && (display_en || text_en)))
            else begin
                n_fail++;
                $error("FAIL excl: de=%0b te=%0b rearm=%0b expected exclusive",
                       display_en, text_en, acq_rearm);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return display_en;
            1:       return text_en;
            default: return acq_rearm;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int lim, input string tag);
        int i;
        i = 0;
        while (sig(sel) !== 1'b1 && i < lim) begin
            @(negedge clk);
            i++;
        end
        n_chk++;
        assert (sig(sel) === 1'b1)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0 after %0d cycles expected 1", tag, lim);
        end
    endtask

    task automatic pulse(input int sel);
        case (sel)
            0:       display_done = 1'b1;
            1:       text_done = 1'b1;
            default: cfg_change = 1'b1;
        endcase
        @(negedge clk);
        display_done = 1'b0;
        text_done    = 1'b0;
        cfg_change   = 1'b0;
    endtask

    task automatic wave_frame(input int hold);
        wait_for(0, 300, "wave_grant");
        repeat (hold) @(negedge clk);
        pulse(0);
    endtask

    initial begin
        int nr;
        int nw;
        int nt;
        int n;
        rst_n        = 1'b0;
        acq_ready    = 1'b1;
        stop         = 1'b0;
        pause        = 1'b0;
        cfg_change   = 1'b0;
        display_done = 1'b0;
        text_done    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rearm", acq_rearm, 0);
        chk("rst_de", display_en, 0);
        chk("rst_te", text_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame", frame_cnt, 0);
        chk("rst_to", timeout_err, 0);

        rst_n = 1'b1;
        @(negedge clk);
        chk("rearm_first", acq_rearm, 1);
        chk("de_early", display_en, 0);
        @(negedge clk);
        chk("de_rise", display_en, 1);
        chk("rearm_once", acq_rearm, 0);
        chk("busy_wave", busy, 1);

        for (int k = 1; k <= 4; k++) begin
            wave_frame(19);
            chk("de_drop", display_en, 0);
            chk("text_follow", text_en, (k % 2 == 0));
            chk("frame_cnt", frame_cnt, k);
            if (k % 2 == 0) begin
                repeat (4) @(negedge clk);
                pulse(1);
                chk("te_drop", text_en, 0);
            end
        end
        for (int i = 1; i < 4; i++)
            chk("spacing", rise_t[i] - rise_t[i-1], 103);
        chk("rearm_count", n_rearm, 4);

        wait_for(0, 300, "wave5");
        repeat (4) @(negedge clk);
        pulse(2);
        repeat (14) @(negedge clk);
        display_done = 1'b1;
        cfg_change   = 1'b1;
        @(negedge clk);
        display_done = 1'b0;
        cfg_change   = 1'b0;
        chk("cfg_text", text_en, 1);
        repeat (4) @(negedge clk);
        pulse(1);
        wave_frame(19);
        chk("cfg_retext", text_en, 1);
        repeat (4) @(negedge clk);
        pulse(1);
        wave_frame(19);
        chk("no_text7", text_en, 0);
        chk("frame7", frame_cnt, 7);

        stop = 1'b1;
        nr = n_rearm;
        nw = rise_t.size();
        nt = n_text;
        repeat (250) @(negedge clk);
        chk("stop_no_rearm", n_rearm, nr);
        chk("stop_no_wave", rise_t.size(), nw);
        pulse(2);
        wave_frame(19);
        chk("stop_text", text_en, 1);
        repeat (4) @(negedge clk);
        pulse(1);
        repeat (300) @(negedge clk);
        chk("stop_one_wave", rise_t.size(), nw + 1);
        chk("stop_one_text", n_text, nt + 1);
        chk("stop_rearm", n_rearm, nr);
        chk("frame8", frame_cnt, 8);

        stop  = 1'b0;
        pause = 1'b1;
        nw = rise_t.size();
        repeat (20) @(negedge clk);
        pulse(2);
        wait_for(1, 200, "pause_text");
        chk("pause_no_de", display_en, 0);
        repeat (4) @(negedge clk);
        pulse(1);
        repeat (300) @(negedge clk);
        chk("pause_no_wave", rise_t.size(), nw);
        chk("pause_rearm", n_rearm, nr);
        chk("pause_frame", frame_cnt, 8);

        pause = 1'b0;
        wait_for(0, 300, "to_wave");
        n = 0;
        while (display_en === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("to_len", n, 50);
        chk("to_err", timeout_err, 1);
        chk("to_frame", frame_cnt, 8);
        pulse(0);
        chk("late_done", frame_cnt, 8);
        wait_for(2, 200, "to_rearm");
        wave_frame(19);
        chk("frame9", frame_cnt, 9);
        chk("no_text9", text_en, 0);
        chk("to_sticky", timeout_err, 1);

        wait_for(0, 300, "arst_wave");
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_de", display_en, 0);
        chk("arst_frame", frame_cnt, 0);
        chk("arst_to", timeout_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_rearm", acq_rearm, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
